// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: per-frame data length, parity, stop bits and bit period.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN (adds input tx_break).
module uart_tx_cfg #(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_WIDTH     = 16,
   parameter bit IDLE_LEVEL    = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [MAX_DATA_BITS-1:0] tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [3:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   input  logic [DIV_WIDTH-1:0]     baud_div,
`ifdef UART_TX_BREAK_EN
   input  logic                     tx_break,
`endif
   output logic                     tx_s,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int IDX_W = $clog2(MAX_DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK,
      S_BRK_HOLD
`endif
   } state_e;

   state_e                   state_q, state_d;
   logic [DIV_WIDTH-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]     div_q, div_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [MAX_DATA_BITS-1:0] data_q, data_d;
   logic [3:0]               nbits_q, nbits_d;
   logic                     par_en_q, par_en_d;
   logic                     par_odd_q, par_odd_d;
   logic                     stop2_q, stop2_d;
   logic                     tx_s_q, tx_s_d;

   logic                     last_tick, last_data, last_stop, frame_end, accept, par_bit;
   logic [3:0]               nbits_clamped;
   logic [DIV_WIDTH-1:0]     div_eff;

   assign last_tick = (cnt_q == div_q - DIV_WIDTH'(1));
   assign last_data = (int'(idx_q) == int'(nbits_q) - 1);
   // In STOP the bit index doubles as the stop-bit counter (0 or 1).
   assign last_stop = ~stop2_q | idx_q[0];
   assign frame_end = (state_q == S_STOP) && last_tick && last_stop;

`ifdef UART_TX_BREAK_EN
   assign tx_ready = ((state_q == S_IDLE) && !tx_break) || frame_end;
`else
   assign tx_ready = (state_q == S_IDLE) || frame_end;
`endif
   assign accept     = tx_valid && tx_ready;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_end;
   assign tx_s       = tx_s_q;

   assign nbits_clamped = (cfg_data_bits < 4'd5)                ? 4'd5 :
                          (cfg_data_bits > 4'(MAX_DATA_BITS))    ? 4'(MAX_DATA_BITS) :
                                                                   cfg_data_bits;
   assign div_eff = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

   always_comb begin
      par_bit = par_odd_q;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < int'(nbits_q)) par_bit = par_bit ^ data_q[i];
      end
   end

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = last_tick ? '0 : cnt_q + DIV_WIDTH'(1);
      idx_d     = idx_q;
      div_d     = div_q;
      data_d    = data_q;
      nbits_d   = nbits_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      stop2_d   = stop2_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_TX_BREAK_EN
            if (tx_break) begin
               state_d = S_BREAK;
               div_d   = div_eff;
            end
`endif
         end
         S_START: begin
            if (last_tick) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (last_tick) begin
               if (last_data) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (last_tick) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
         S_STOP: begin
            if (last_tick) begin
               if (last_stop) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            cnt_d = '0;
            if (!tx_break) state_d = S_BRK_HOLD;
         end
         S_BRK_HOLD: begin
            if (last_tick) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Accept can only happen in IDLE or the final stop cycle; it overrides both.
      if (accept) begin
         state_d   = S_START;
         cnt_d     = '0;
         idx_d     = '0;
         data_d    = tx_data;
         nbits_d   = nbits_clamped;
         par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         par_odd_d = (cfg_parity == 2'b10);
         stop2_d   = cfg_stop2;
         div_d     = div_eff;
      end
   end

   // Line level is registered from the next state so the start bit appears the cycle after accept.
   always_comb begin
      tx_s_d = IDLE_LEVEL;
      case (state_d)
         S_START:  tx_s_d = ~IDLE_LEVEL;
         S_DATA:   tx_s_d = data_q[idx_d];
         S_PARITY: tx_s_d = par_bit;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  tx_s_d = ~IDLE_LEVEL;
`endif
         default:  tx_s_d = IDLE_LEVEL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= DIV_WIDTH'(1);
         idx_q     <= '0;
         data_q    <= '0;
         nbits_q   <= 4'd5;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_s_q    <= IDLE_LEVEL;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         nbits_q   <= nbits_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         stop2_q   <= stop2_d;
         tx_s_q    <= tx_s_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: frames are predicted as per-cycle line levels from the frame rules.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [3:0]  cfg_data_bits = 4'd8;
   logic [1:0]  cfg_parity = 2'b00;
   logic        cfg_stop2 = 1'b0;
   logic [15:0] baud_div = 16'd1;
   logic        tx_s, busy, frame_done;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int fd_cnt     = 0;
   int fd_times[$];
   logic exp_q[$];

   uart_tx_cfg dut (
      .clk           (clk),
      .rst           (rst),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .baud_div      (baud_div),
      .tx_s          (tx_s),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         fd_cnt++;
         fd_times.push_back(cyc);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected line level for every cycle of a frame, from the frame-format rules.
   task automatic build_frame(input logic [8:0] data, input int nbits_raw, input int par,
                              input bit stop2, input int div_raw);
      int n, d, ones, nstop;
      logic pbit;
      n     = (nbits_raw < 5) ? 5 : (nbits_raw > 9) ? 9 : nbits_raw;
      d     = (div_raw == 0) ? 1 : div_raw;
      nstop = stop2 ? 2 : 1;
      ones  = 0;
      for (int i = 0; i < n; i++) ones += int'(data[i]);
      pbit  = (ones % 2 == 1);
      if (par == 2) pbit = ~pbit;
      exp_q.delete();
      for (int c = 0; c < d; c++) exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++)
         for (int c = 0; c < d; c++) exp_q.push_back(data[i]);
      if (par == 1 || par == 2)
         for (int c = 0; c < d; c++) exp_q.push_back(pbit);
      for (int s = 0; s < nstop; s++)
         for (int c = 0; c < d; c++) exp_q.push_back(1'b1);
   endtask

   task automatic do_accept(input logic [8:0] data, input int nbits_raw, input int par,
                            input bit stop2, input int div_raw, input bit hold_valid);
      int waited = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (tx_ready !== 1'b1) begin
         compared++;
         mismatched++;
         $display("FAIL accept_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, waited);
      end
      tx_data       = data;
      cfg_data_bits = 4'(nbits_raw);
      cfg_parity    = 2'(par);
      cfg_stop2     = stop2;
      baud_div      = 16'(div_raw);
      tx_valid      = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_valid) begin
         tx_valid      = 1'b0;
         tx_data       = 9'($urandom);
         cfg_data_bits = 4'($urandom);
         cfg_parity    = 2'($urandom);
         cfg_stop2     = 1'($urandom);
         baud_div      = 16'($urandom_range(0, 20));
      end
      build_frame(data, nbits_raw, par, stop2, div_raw);
   endtask

   // Compares {tx_s, busy, frame_done, tx_ready} on every cycle of the predicted frame.
   task automatic observe_frame(input string name, input bit b2b);
      int n;
      logic [3:0] got, exp;
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         got = {tx_s, busy, frame_done, tx_ready};
         exp = {exp_q[k], 1'b1, (k == n - 1), (k == n - 1)};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: tx_s/busy/done/ready=%b, required %b", name, k, got, exp);
         end
      end
      if (!b2b) begin
         @(negedge clk);
         got = {tx_s, busy, frame_done, tx_ready};
         compared++;
         if (got !== 4'b1001) begin
            mismatched++;
            $display("FAIL %s idle_after: tx_s/busy/done/ready=%b, required 1001", name, got);
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] got;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      got = {tx_s, busy, frame_done, tx_ready};
      compared++;
      if (got !== 4'b1001) begin
         mismatched++;
         $display("FAIL reset_state: tx_s/busy/done/ready=%b, required 1001", got);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      do_accept(9'h0A5, 8, 0, 1'b0, 4, 1'b0);
      observe_frame("basic_8n1_div4", 1'b0);
   endtask

   task automatic test_parity();
      do_accept(9'h0A5, 8, 1, 1'b0, 2, 1'b0);
      observe_frame("parity_even", 1'b0);
      do_accept(9'h0A5, 8, 2, 1'b0, 2, 1'b0);
      observe_frame("parity_odd", 1'b0);
      do_accept(9'h0A5, 8, 3, 1'b0, 2, 1'b0);
      observe_frame("parity_mode3_none", 1'b0);
   endtask

   task automatic test_upper_bits();
      do_accept(9'h1FF, 7, 1, 1'b1, 1, 1'b0);
      observe_frame("seven_bits_stop2", 1'b0);
   endtask

   task automatic test_back_to_back();
      int fd_before;
      fd_before = fd_cnt;
      do_accept(9'h055, 8, 0, 1'b0, 3, 1'b1);
      tx_data = 9'h00F;
      observe_frame("b2b_first", 1'b1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      build_frame(9'h00F, 8, 0, 1'b0, 3);
      observe_frame("b2b_second", 1'b0);
      compared++;
      if (fd_cnt - fd_before !== 2) begin
         mismatched++;
         $display("FAIL b2b_done_count: %0d pulses, required 2", fd_cnt - fd_before);
      end
      compared++;
      if (fd_times.size() < 2 || fd_times[$] - fd_times[$-1] !== 30) begin
         mismatched++;
         $display("FAIL b2b_done_spacing: pulses not 30 cycles apart");
      end
   endtask

   task automatic test_clamp_min();
      do_accept(9'($urandom), 2, 0, 1'b0, 0, 1'b0);
      baud_div      = 16'd9;
      cfg_data_bits = 4'd15;
      observe_frame("clamp_div0_bits2", 1'b0);
      do_accept(9'($urandom), 15, 1, 1'b0, 2, 1'b0);
      observe_frame("clamp_bits15", 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [8:0] d;
      logic [3:0] got;
      d = 9'($urandom);
      do_accept(d, 8, 0, 1'b0, 4, 1'b0);
      repeat (17) @(negedge clk);
      compared++;
      if (tx_s !== d[3]) begin
         mismatched++;
         $display("FAIL reset_mid_bit3: tx_s=%b, required %b", tx_s, d[3]);
      end
      #1 rst = 1'b1;
      #1;
      got = {tx_s, busy, frame_done, tx_ready};
      compared++;
      if (got !== 4'b1001) begin
         mismatched++;
         $display("FAIL reset_mid_async: tx_s/busy/done/ready=%b, required 1001", got);
      end
      @(negedge clk);
      rst = 1'b0;
      do_accept(9'($urandom), $urandom_range(5, 9), $urandom_range(0, 3), 1'($urandom),
                $urandom_range(1, 4), 1'b0);
      observe_frame("after_reset_frame", 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         do_accept(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 5), 1'b0);
         observe_frame($sformatf("random_%0d", t), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_upper_bits();
      test_back_to_back();
      test_clamp_min();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
